// File: rtl/sc_relay_sequencer.sv
// Power-path sequencer: turns a charge request into precharge, relay close and current ramp,
// with instant abort on fault or grid loss, exponential retry backoff and lockout.
module sc_relay_sequencer #(
  parameter int PRECHARGE_CYC = 16,
  parameter int SETTLE_CYC    = 4,
  parameter int CUR_W         = 8,
  parameter int I_MAX         = 200,
  parameter int RAMP_STEP     = 10,
  parameter int BACKOFF_CYC   = 32,
  parameter int MAX_RETRIES   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             charge_enable,
  input  logic             battery_connected,
  input  logic             battery_full,
  input  logic             grid_ok,
  input  logic             ml_predict_instability,
  input  logic             fault_flag,
  output logic             precharge_en,
  output logic             relay_activation,
  output logic [CUR_W-1:0] current_limit,
  output logic [3:0]       seq_state,
  output logic [2:0]       retry_count,
  output logic             lockout
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PRECHARGE = 4'd1,
    S_CLOSE     = 4'd2,
    S_RAMP      = 4'd3,
    S_CHARGE    = 4'd4,
    S_RAMP_DOWN = 4'd5,
    S_OPEN      = 4'd6,
    S_BACKOFF   = 4'd7,
    S_LOCKOUT   = 4'd8
  } state_t;

  localparam logic [CUR_W-1:0] FULL_I       = CUR_W'(I_MAX);
  localparam logic [CUR_W-1:0] HALF_I       = CUR_W'(I_MAX >> 1);
  localparam logic [CUR_W-1:0] STEP_I       = CUR_W'(RAMP_STEP);
  localparam logic [CUR_W:0]   STEP_W       = (CUR_W+1)'(RAMP_STEP);
  localparam logic [31:0]      PRE_LOAD     = 32'(PRECHARGE_CYC - 1);
  localparam logic [31:0]      SETTLE_LOAD  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0]      BACKOFF_BASE = 32'(BACKOFF_CYC);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  state_t             state;
  logic [31:0]        timer;
  logic               go;
  logic               abort;
  logic               stop;
  logic               abortable;
  logic               timer_done;
  logic [CUR_W-1:0]   target;
  logic [CUR_W-1:0]   toward_next;
  logic [CUR_W-1:0]   down_next;
  logic [CUR_W:0]     cur_w;
  logic [CUR_W:0]     tgt_w;
  logic [CUR_W:0]     up_sum;

  assign seq_state = state;

  // Request decode plus the next ramp values; sums are one bit wider so a step never wraps.
  always_comb begin
    go         = charge_enable & battery_connected & ~battery_full & grid_ok & ~fault_flag;
    abort      = fault_flag | ~grid_ok;
    stop       = ~charge_enable | battery_full | ~battery_connected;
    target     = ml_predict_instability ? HALF_I : FULL_I;
    abortable  = state inside {S_PRECHARGE, S_CLOSE, S_RAMP, S_CHARGE, S_RAMP_DOWN};
    timer_done = (timer == 32'd0);
    cur_w      = {1'b0, current_limit};
    tgt_w      = {1'b0, target};
    up_sum     = cur_w + STEP_W;
    if (cur_w < tgt_w)
      toward_next = (up_sum > tgt_w) ? target : up_sum[CUR_W-1:0];
    else if (cur_w > tgt_w)
      toward_next = (cur_w < tgt_w + STEP_W) ? target : current_limit - STEP_I;
    else
      toward_next = current_limit;
    down_next = (current_limit <= STEP_I) ? '0 : current_limit - STEP_I;
  end

  // Timers are loaded with residency-1 and the state is left on the edge that finds them at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      timer            <= '0;
      precharge_en     <= 1'b0;
      relay_activation <= 1'b0;
      current_limit    <= '0;
      retry_count      <= '0;
      lockout          <= 1'b0;
    end else if (abortable && abort) begin
      state            <= S_BACKOFF;
      timer            <= (BACKOFF_BASE << retry_count) - 32'd1;
      precharge_en     <= 1'b0;
      relay_activation <= 1'b0;
      current_limit    <= '0;
      if (retry_count != 3'd7)
        retry_count <= retry_count + 3'd1;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state        <= S_PRECHARGE;
            timer        <= PRE_LOAD;
            precharge_en <= 1'b1;
          end
        end
        S_PRECHARGE: begin
          if (stop) begin
            state        <= S_IDLE;
            timer        <= '0;
            precharge_en <= 1'b0;
          end else if (timer_done) begin
            state            <= S_CLOSE;
            timer            <= SETTLE_LOAD;
            relay_activation <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_CLOSE: begin
          if (stop) begin
            state            <= S_OPEN;
            timer            <= SETTLE_LOAD;
            precharge_en     <= 1'b0;
            relay_activation <= 1'b0;
          end else if (timer_done) begin
            state        <= S_RAMP;
            precharge_en <= 1'b0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_RAMP: begin
          if (stop) begin
            state <= S_RAMP_DOWN;
          end else begin
            current_limit <= toward_next;
            if (toward_next == target)
              state <= S_CHARGE;
          end
        end
        S_CHARGE: begin
          if (stop)
            state <= S_RAMP_DOWN;
          else
            current_limit <= toward_next;
        end
        S_RAMP_DOWN: begin
          current_limit <= down_next;
          if (down_next == '0) begin
            state            <= S_OPEN;
            timer            <= SETTLE_LOAD;
            relay_activation <= 1'b0;
          end
        end
        S_OPEN: begin
          if (timer_done) begin
            state       <= S_IDLE;
            retry_count <= '0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_BACKOFF: begin
          if (retry_count >= RETRY_LIMIT) begin
            state   <= S_LOCKOUT;
            timer   <= '0;
            lockout <= 1'b1;
          end else if (timer_done) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_LOCKOUT: begin
          if (!charge_enable) begin
            state       <= S_IDLE;
            retry_count <= '0;
            lockout     <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_relay_sequencer.sv
// Self-checking bench for sc_relay_sequencer: hand-derived vector table, directed corner
// sequences and a randomized run, all shadowed cycle by cycle by a behavioural model.
module tb_sc_relay_sequencer;

  localparam int PRECHARGE_CYC = 16;
  localparam int SETTLE_CYC    = 4;
  localparam int CUR_W         = 8;
  localparam int I_MAX         = 200;
  localparam int RAMP_STEP     = 10;
  localparam int BACKOFF_CYC   = 32;
  localparam int MAX_RETRIES   = 3;

  // Input bundles ordered {charge_enable, battery_connected, battery_full, grid_ok, ml, fault}
  localparam logic [5:0] IN_IDLE   = 6'b010100;
  localparam logic [5:0] IN_GO     = 6'b110100;
  localparam logic [5:0] IN_ML     = 6'b110110;
  localparam logic [5:0] IN_FAULT  = 6'b110101;
  localparam logic [5:0] IN_FULL   = 6'b111100;
  localparam logic [5:0] IN_NOGRID = 6'b110000;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce, bc, bf, grid, ml, fault;
  logic             precharge_en, relay_activation, lockout;
  logic [CUR_W-1:0] current_limit;
  logic [3:0]       seq_state;
  logic [2:0]       retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_relay_sequencer #(
    .PRECHARGE_CYC(PRECHARGE_CYC), .SETTLE_CYC(SETTLE_CYC), .CUR_W(CUR_W), .I_MAX(I_MAX),
    .RAMP_STEP(RAMP_STEP), .BACKOFF_CYC(BACKOFF_CYC), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .rst(rst), .charge_enable(ce), .battery_connected(bc), .battery_full(bf),
    .grid_ok(grid), .ml_predict_instability(ml), .fault_flag(fault),
    .precharge_en(precharge_en), .relay_activation(relay_activation),
    .current_limit(current_limit), .seq_state(seq_state), .retry_count(retry_count),
    .lockout(lockout)
  );

  // Reference model: phase number, cycles spent so far in the phase, current and abort history.
  int m_state, m_cur, m_elapsed, m_retry, m_backoff_len;

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
    return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_elapsed = 0; m_retry = 0; m_backoff_len = 0;
  endtask

  task automatic model_step();
    bit go_i, abort_i, stop_i;
    int tgt;
    go_i    = ce && bc && !bf && grid && !fault;
    abort_i = fault || !grid;
    stop_i  = !ce || bf || !bc;
    tgt     = ml ? I_MAX / 2 : I_MAX;
    if (m_state >= 1 && m_state <= 5 && abort_i) begin
      m_backoff_len = BACKOFF_CYC * (2 ** m_retry);
      m_retry       = (m_retry < 7) ? m_retry + 1 : 7;
      m_state = 7; m_elapsed = 1; m_cur = 0;
    end else begin
      case (m_state)
        0: if (go_i) begin m_state = 1; m_elapsed = 1; end
        1: if (stop_i) m_state = 0;
           else if (m_elapsed == PRECHARGE_CYC) begin m_state = 2; m_elapsed = 1; end
           else m_elapsed++;
        2: if (stop_i) begin m_state = 6; m_elapsed = 1; end
           else if (m_elapsed == SETTLE_CYC) m_state = 3;
           else m_elapsed++;
        3: if (stop_i) m_state = 5;
           else begin
             m_cur = toward(m_cur, tgt);
             if (m_cur == tgt) m_state = 4;
           end
        4: if (stop_i) m_state = 5;
           else m_cur = toward(m_cur, tgt);
        5: begin
             m_cur = (m_cur > RAMP_STEP) ? m_cur - RAMP_STEP : 0;
             if (m_cur == 0) begin m_state = 6; m_elapsed = 1; end
           end
        6: if (m_elapsed == SETTLE_CYC) begin m_state = 0; m_retry = 0; end
           else m_elapsed++;
        7: if (m_retry >= MAX_RETRIES) m_state = 8;
           else if (m_elapsed == m_backoff_len) m_state = 0;
           else m_elapsed++;
        8: if (!ce) begin m_state = 0; m_retry = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic expectVals(input int st, input int cur, input bit pre, input bit relay,
                            input int retry, input bit lock, input string tag);
    checks++;
    if (seq_state !== 4'(st) || current_limit !== CUR_W'(cur) || precharge_en !== pre ||
        relay_activation !== relay || retry_count !== 3'(retry) || lockout !== lock) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual st=%0d cur=%0d pre=%0b rly=%0b rty=%0d lock=%0b required st=%0d cur=%0d pre=%0b rly=%0b rty=%0d lock=%0b",
               tag, $time, seq_state, current_limit, precharge_en, relay_activation, retry_count,
               lockout, st, cur, pre, relay, retry, lock);
    end
  endtask

  // Outputs implied by the model phase: power outputs are pure functions of where we are.
  task automatic checkOutput(input string tag);
    bit exp_pre, exp_relay, exp_lock;
    exp_pre   = (m_state == 1 || m_state == 2);
    exp_relay = (m_state >= 2 && m_state <= 5);
    exp_lock  = (m_state == 8);
    expectVals(m_state, m_cur, exp_pre, exp_relay, m_retry, exp_lock, {"model_", tag});
  endtask

  task automatic applyStimulus(input logic [5:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      {ce, bc, bf, grid, ml, fault} = v;
      @(posedge clk);
      model_step();
      #1;
      checkOutput(tag);
    end
  endtask

  typedef struct {
    logic [5:0] vin;
    int         n;
    int         st;
    int         cur;
    bit         pre;
    bit         relay;
    int         retry;
    bit         lock;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] vin, input int n, input int st, input int cur,
                     input bit pre, input bit relay, input int retry, input bit lock);
    vec_t v;
    v.vin = vin; v.n = n; v.st = st; v.cur = cur;
    v.pre = pre; v.relay = relay; v.retry = retry; v.lock = lock;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] rv;
    rst = 1'b1;
    {ce, bc, bf, grid, ml, fault} = IN_IDLE;
    model_reset();

    //   inputs     cyc  st  cur pre rly rty lock
    add(IN_IDLE,     2,  0,   0, 0, 0, 0, 0);
    add(IN_GO,       1,  1,   0, 1, 0, 0, 0);
    add(IN_GO,      15,  1,   0, 1, 0, 0, 0);
    add(IN_GO,       1,  2,   0, 1, 1, 0, 0);
    add(IN_GO,       3,  2,   0, 1, 1, 0, 0);
    add(IN_GO,       1,  3,   0, 0, 1, 0, 0);
    add(IN_GO,       1,  3,  10, 0, 1, 0, 0);
    add(IN_GO,      18,  3, 190, 0, 1, 0, 0);
    add(IN_GO,       1,  4, 200, 0, 1, 0, 0);
    add(IN_ML,       1,  4, 190, 0, 1, 0, 0);
    add(IN_ML,       9,  4, 100, 0, 1, 0, 0);
    add(IN_ML,       3,  4, 100, 0, 1, 0, 0);
    add(IN_GO,      10,  4, 200, 0, 1, 0, 0);
    add(IN_FAULT,    1,  7,   0, 0, 0, 1, 0);
    add(IN_GO,      31,  7,   0, 0, 0, 1, 0);
    add(IN_GO,       1,  0,   0, 0, 0, 1, 0);
    add(IN_GO,      41,  4, 200, 0, 1, 1, 0);
    add(IN_FULL,     1,  5, 200, 0, 1, 1, 0);
    add(IN_FULL,    19,  5,  10, 0, 1, 1, 0);
    add(IN_FULL,     1,  6,   0, 0, 0, 1, 0);
    add(IN_FULL,     3,  6,   0, 0, 0, 1, 0);
    add(IN_FULL,     1,  0,   0, 0, 0, 0, 0);
    add(IN_GO,       1,  1,   0, 1, 0, 0, 0);
    add(IN_FAULT,    1,  7,   0, 0, 0, 1, 0);
    add(IN_GO,      32,  0,   0, 0, 0, 1, 0);
    add(IN_GO,       1,  1,   0, 1, 0, 1, 0);
    add(IN_NOGRID,   1,  7,   0, 0, 0, 2, 0);
    add(IN_GO,      63,  7,   0, 0, 0, 2, 0);
    add(IN_GO,       1,  0,   0, 0, 0, 2, 0);
    add(IN_GO,       1,  1,   0, 1, 0, 2, 0);
    add(IN_FAULT,    1,  7,   0, 0, 0, 3, 0);
    add(IN_GO,       1,  8,   0, 0, 0, 3, 1);
    add(IN_GO,       5,  8,   0, 0, 0, 3, 1);
    add(IN_IDLE,     1,  0,   0, 0, 0, 0, 0);
    add(IN_GO,       1,  1,   0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    expectVals(0, 0, 0, 0, 0, 0, "reset_state");
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].vin, tbl[i].n, $sformatf("vec%0d", i));
      expectVals(tbl[i].st, tbl[i].cur, tbl[i].pre, tbl[i].relay, tbl[i].retry, tbl[i].lock,
                 $sformatf("vec%0d", i));
    end

    // Stop during CLOSE opens the relay through the settle window without counting a retry.
    applyStimulus(IN_GO, 16, "close_entry");
    expectVals(2, 0, 1, 1, 0, 0, "close_reached");
    applyStimulus(IN_IDLE, 1, "close_stop");
    expectVals(6, 0, 0, 0, 0, 0, "close_stop_open");
    applyStimulus(IN_IDLE, 4, "open_settle");
    expectVals(0, 0, 0, 0, 0, 0, "open_to_idle");

    // Stop during PRECHARGE returns straight to IDLE.
    applyStimulus(IN_GO, 3, "pre_entry");
    applyStimulus(IN_FULL, 1, "pre_stop");
    expectVals(0, 0, 0, 0, 0, 0, "pre_stop_idle");

    // Asynchronous reset in the middle of a ramp clears outputs without a clock edge.
    applyStimulus(IN_GO, 28, "ramp_to_70");
    expectVals(3, 70, 0, 1, 0, 0, "ramp_at_70");
    {ce, bc, bf, grid, ml, fault} = IN_IDLE;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    expectVals(0, 0, 0, 0, 0, 0, "async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized run against the model.
    ml = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) ml = ~ml;
      rv[5] = ($urandom_range(0, 39) != 0);
      rv[4] = ($urandom_range(0, 99) != 0);
      rv[3] = ($urandom_range(0, 79) == 0);
      rv[2] = ($urandom_range(0, 149) != 0);
      rv[1] = ml;
      rv[0] = ($urandom_range(0, 199) == 0);
      applyStimulus(rv, 1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
